filter_stream_aligner: RTL and testbench
========================================

Name: filter_stream_aligner

Overview:
- Read-side controller for the filtered-data delay line that compensates FIR group delay (filter order / 2).
- Accepts one projection line of raw samples and drives the delay line's enable/clear/data.
- Discards the stale start-up samples the delay line emits, then flushes the tail with zeros.
- Presents exactly pLineLength aligned samples per line to the back-projection datapath over a valid/ready handshake.

Parameters:
- pDelayLength, 8: enable pulses between writing a sample into the delay line and that sample appearing on sr_val_out; must be >= 2.
- pDataLength, 16: filtered sample width.
- pLineLength, 256: samples per projection line; must be >= 2.
- pCntLength, 9: counter width; must satisfy 2^pCntLength > pLineLength + pDelayLength.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  upstream may transfer.
- in_data  in  pDataLength  upstream sample.
- sr_enable  out  1  delay-line advance strobe.
- sr_clear  out  1  delay-line clear strobe.
- sr_val_in  out  pDataLength  delay-line write data.
- sr_val_out  in  pDataLength  delay-line read data; valid the cycle after sr_enable.
- out_valid  out  1  aligned sample valid.
- out_ready  in  1  downstream accept.
- out_data  out  pDataLength  aligned sample.
- out_last  out  1  marks the final sample of a line.
- busy  out  1  high from line start until CLEAR completes.

Behaviour:
- Reset (async, reset_n=0):
  - state=CLEAR; counters 0.
  - out_valid, out_last, busy, sr_enable, in_ready = 0; out_data = 0.
  - sr_clear = 1.
- Transfer rules:
  - Upstream transfer: in_valid & in_ready.
  - Downstream transfer: out_valid & out_ready.
  - out_valid holds with out_data/out_last stable until accepted.
- Output slot: single register; slot_free = ~out_valid | out_ready.
- States:
  - CLEAR: sr_clear=1 for one cycle, then IDLE. Entered from reset or after DONE.
  - IDLE: in_ready=slot_free; busy=0. First upstream transfer -> PRIME, busy=1.
  - PRIME: in_ready=slot_free.
    - Each transfer pulses sr_enable with sr_val_in=in_data; nothing is produced downstream.
    - After pDelayLength transfers -> STREAM.
  - STREAM: in_ready=slot_free.
    - Each transfer pulses sr_enable; the cycle after, sr_val_out loads into out_data and out_valid=1.
    - When in_cnt reaches pLineLength -> FLUSH.
  - FLUSH: in_ready=0.
    - When slot_free, pulse sr_enable with sr_val_in=0; capture as in STREAM.
    - After pDelayLength pulses -> DONE.
  - DONE: wait for the final downstream transfer (out_cnt==pLineLength) -> CLEAR.
- Counters:
  - in_cnt counts upstream transfers.
  - out_cnt counts downstream transfers.
  - Both reset in CLEAR; no wrap within a line.
- Per-line totals: pLineLength + pDelayLength enables.
  - Outputs = enables − pDelayLength = pLineLength.
- out_last=1 exactly when the sample with out_cnt==pLineLength−1 is presented.
- Latency: sample k at out_data one cycle after enable number k+pDelayLength.
- Backpressure: sr_enable is never pulsed while the output slot is held. A simultaneous accept and new capture in one cycle is legal (no bubble).
- Mid-line reset: async clear to reset values; the delay line is cleared by the CLEAR state before the next line.
- in_valid in FLUSH/DONE/CLEAR is ignored (in_ready=0).

Optional Feature:
- Macro: FILTER_STREAM_ALIGNER_CHECK_EN.
- Defined:
  - Adds input in_last and output err_len (sticky, cleared only by reset_n).
  - err_len is set if in_last accompanies a transfer with in_cnt != pLineLength−1, or if in_cnt reaches pLineLength−1 without in_last.
- Undefined:
  - Neither port exists; line length is set purely by pLineLength.

Decomposition:
- Shared package nabp_filter_pkg:
  - state enum {CLEAR, IDLE, PRIME, STREAM, FLUSH, DONE}.
  - default pDelayLength (filter order / 2), pDataLength.
- One natural sub-module: filter_stream_out_reg. Holds the output register and valid/ready slot logic and generates slot_free.

Test Plan:
- Ungated flow, pDelayLength=4, pLineLength=8, in_data=1..8, out_ready=1 -> out_data 1..8 in order; out_last only on 8; exactly 12 sr_enable pulses; sr_clear pulse afterwards; busy then falls.
- Backpressure: out_ready toggled 1,0,0,1 repeating -> no sample lost or duplicated; sr_enable never pulses while out_valid=1 and out_ready=0.
- Back-to-back lines: second line data 101..108 offered immediately -> the first output of line 2 is 101, not a stale value or zero.
- Reset mid-STREAM after 3 outputs -> out_valid=0 asynchronously; next line's outputs start cleanly at its first sample.
- in_valid held in FLUSH -> in_ready=0; sr_val_in=0 for all 4 flush enables.
- With FILTER_STREAM_ALIGNER_CHECK_EN: in_last on sample 6 of 8 -> err_len=1 and stays set until reset_n.

Source files
------------

// File: rtl/nabp_filter_pkg.sv
// Shared types and defaults for the filtered-data delay-line read side.
// Feature macro used by filter_stream_aligner: FILTER_STREAM_ALIGNER_CHECK_EN.
`timescale 1ns/1ps
package nabp_filter_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    PRIME,
    STREAM,
    FLUSH,
    DONE
  } state_t;

  // Group delay of the FIR (filter order / 2) and filtered sample width.
  localparam int DEFAULT_DELAY_LENGTH = 8;
  localparam int DEFAULT_DATA_LENGTH  = 16;

endpackage

// File: rtl/filter_stream_out_reg.sv
// Single-entry output register with valid/ready hold; slot_free says a new
// sample may be written this cycle (slot empty or being drained right now).
`timescale 1ns/1ps
module filter_stream_out_reg #(
  parameter int pDataLength = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic [pDataLength-1:0] load_data,
  input  logic                   load_last,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [pDataLength-1:0] out_data,
  output logic                   out_last,
  output logic                   slot_free
);

  logic                   valid_reg;
  logic [pDataLength-1:0] data_reg;
  logic                   last_reg;

  assign slot_free = ~valid_reg | out_ready;

  // Callers only assert load while slot_free, so a held sample is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
      last_reg  <= load_last;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_last  = last_reg;

endmodule

// File: rtl/filter_stream_aligner.sv
// Read-side controller for the FIR group-delay line: primes, streams, flushes
// and clears it so each line yields exactly pLineLength aligned samples.
// Optional length checking (in_last / err_len): FILTER_STREAM_ALIGNER_CHECK_EN.
`timescale 1ns/1ps
module filter_stream_aligner
  import nabp_filter_pkg::*;
#(
  parameter int pDelayLength = DEFAULT_DELAY_LENGTH,
  parameter int pDataLength  = DEFAULT_DATA_LENGTH,
  parameter int pLineLength  = 256,
  parameter int pCntLength   = 9
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [pDataLength-1:0] in_data,
  output logic                   sr_enable,
  output logic                   sr_clear,
  output logic [pDataLength-1:0] sr_val_in,
  input  logic [pDataLength-1:0] sr_val_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [pDataLength-1:0] out_data,
  output logic                   out_last,
`ifdef FILTER_STREAM_ALIGNER_CHECK_EN
  input  logic                   in_last,
  output logic                   err_len,
`endif
  output logic                   busy
);

  localparam logic [pCntLength-1:0] LINE_CNT  = pCntLength'(pLineLength);
  localparam logic [pCntLength-1:0] DELAY_CNT = pCntLength'(pDelayLength);
  localparam logic [pCntLength-1:0] LAST_EN   = pCntLength'(pLineLength + pDelayLength - 1);
  localparam logic [pCntLength-1:0] CNT_ONE   = pCntLength'(1);

  state_t                state_reg, state_next;
  logic [pCntLength-1:0] in_cnt_reg;
  logic [pCntLength-1:0] en_cnt_reg;
  logic [pCntLength-1:0] out_cnt_reg;
  logic                  cap_pend_reg;
  logic                  cap_last_reg;
  logic                  busy_reg;

  logic slot_free;
  logic up_xfer;
  logic out_xfer;
  logic capture;

  assign out_xfer = out_valid & out_ready;
  // sr_val_out holds while no enable is issued, so a pending capture can wait for the slot.
  assign capture  = cap_pend_reg & slot_free;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    sr_enable  = 1'b0;
    sr_clear   = 1'b0;
    sr_val_in  = '0;
    up_xfer    = 1'b0;
    case (state_reg)
      CLEAR: begin
        sr_clear   = 1'b1;
        state_next = IDLE;
      end
      IDLE, PRIME, STREAM: begin
        in_ready = slot_free;
        up_xfer  = in_valid & slot_free;
        if (up_xfer) begin
          sr_enable = 1'b1;
          sr_val_in = in_data;
          if (in_cnt_reg + CNT_ONE == LINE_CNT) begin
            state_next = FLUSH;
          end else if (en_cnt_reg + CNT_ONE >= DELAY_CNT) begin
            state_next = STREAM;
          end else begin
            state_next = PRIME;
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          sr_enable = 1'b1;
          if (en_cnt_reg == LAST_EN) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (out_cnt_reg == LINE_CNT) begin
          state_next = CLEAR;
        end
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= CLEAR;
    end else begin
      state_reg <= state_next;
    end
  end

  // The first pDelayLength enables only push stale start-up words out of the line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_cnt_reg   <= '0;
      en_cnt_reg   <= '0;
      out_cnt_reg  <= '0;
      cap_pend_reg <= 1'b0;
      cap_last_reg <= 1'b0;
    end else if (state_reg == CLEAR) begin
      in_cnt_reg   <= '0;
      en_cnt_reg   <= '0;
      out_cnt_reg  <= '0;
      cap_pend_reg <= 1'b0;
      cap_last_reg <= 1'b0;
    end else begin
      if (up_xfer) begin
        in_cnt_reg <= in_cnt_reg + CNT_ONE;
      end
      if (out_xfer) begin
        out_cnt_reg <= out_cnt_reg + CNT_ONE;
      end
      if (sr_enable) begin
        en_cnt_reg   <= en_cnt_reg + CNT_ONE;
        cap_pend_reg <= (en_cnt_reg >= DELAY_CNT);
        cap_last_reg <= (en_cnt_reg == LAST_EN);
      end else if (capture) begin
        cap_pend_reg <= 1'b0;
        cap_last_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_reg <= 1'b0;
    end else if (state_reg == CLEAR) begin
      busy_reg <= 1'b0;
    end else if (state_reg == IDLE && up_xfer) begin
      busy_reg <= 1'b1;
    end
  end

  assign busy = busy_reg;

  filter_stream_out_reg #(
    .pDataLength(pDataLength)
  ) u_out_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (capture),
    .load_data (sr_val_out),
    .load_last (cap_last_reg),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .slot_free (slot_free)
  );

`ifdef FILTER_STREAM_ALIGNER_CHECK_EN
  logic err_len_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_len_reg <= 1'b0;
    end else if (up_xfer && (in_last != (in_cnt_reg == LINE_CNT - CNT_ONE))) begin
      err_len_reg <= 1'b1;
    end
  end

  assign err_len = err_len_reg;
`endif

endmodule

// File: tb/tb_filter_stream_aligner.sv
// Directed bench for filter_stream_aligner with a behavioural delay line.
// Covers FILTER_STREAM_ALIGNER_CHECK_EN when that macro is defined.
`timescale 1ns/1ps
module tb_filter_stream_aligner;

  localparam int D  = 4;
  localparam int L  = 8;
  localparam int DW = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          sr_enable;
  logic          sr_clear;
  logic [DW-1:0] sr_val_in;
  logic [DW-1:0] sr_val_out;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
`ifdef FILTER_STREAM_ALIGNER_CHECK_EN
  logic          in_last;
  logic          err_len;
  int            last_pos = L - 1;
`endif

  int compares = 0;
  int fails    = 0;

  always #5 clk = ~clk;

  filter_stream_aligner #(
    .pDelayLength(D),
    .pDataLength (DW),
    .pLineLength (L),
    .pCntLength  (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .sr_enable  (sr_enable),
    .sr_clear   (sr_clear),
    .sr_val_in  (sr_val_in),
    .sr_val_out (sr_val_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
`ifdef FILTER_STREAM_ALIGNER_CHECK_EN
    .in_last    (in_last),
    .err_len    (err_len),
`endif
    .busy       (busy)
  );

  // Delay line: a word written by enable e appears on sr_val_out after enable e+D.
  logic [DW-1:0] dl [0:D];
  always @(posedge clk) begin
    if (sr_clear) begin
      for (int i = 0; i <= D; i++) dl[i] <= '0;
    end else if (sr_enable) begin
      dl[0] <= sr_val_in;
      for (int i = 1; i <= D; i++) dl[i] <= dl[i-1];
    end
  end
  assign sr_val_out = dl[D];

  // Monitor on the falling edge; inputs only change just after the rising edge.
  int            en_count = 0;
  int            clr_count = 0;
  int            up_count = 0;
  int            bp_viol = 0;
  logic [DW-1:0] en_val_q [$];
  logic [DW-1:0] out_q [$];
  logic          last_q [$];
  always @(negedge clk) begin
    if (reset_n) begin
      if (sr_enable) begin
        en_count++;
        en_val_q.push_back(sr_val_in);
        if (out_valid && !out_ready) bp_viol++;
      end
      if (sr_clear) clr_count++;
      if (in_valid && in_ready) up_count++;
      if (out_valid && out_ready) begin
        out_q.push_back(out_data);
        last_q.push_back(out_last);
      end
    end
  end

  logic [DW-1:0] stim_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int idx);
    if (idx < stim_q.size()) begin
      in_valid = 1'b1;
      in_data  = stim_q[idx];
    end else begin
      in_valid = 1'b0;
      in_data  = '0;
    end
`ifdef FILTER_STREAM_ALIGNER_CHECK_EN
    in_last = in_valid && ((idx % L) == last_pos);
`endif
  endtask

  // Feeds stim_q; stops after stop_outs outputs (if nonzero) or when the last line has cleared.
  task automatic run(input bit bp, input int stop_outs);
    int idx = 0;
    int cyc = 0;
    int obase = out_q.size();
    bit take;
    bit seen_busy = 1'b0;
    bit done = 1'b0;
    set_in(0);
    while (!done && cyc < 600) begin
      out_ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      @(negedge clk);
      take = in_valid && in_ready;
      if (busy) seen_busy = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      if (take) begin
        idx++;
        set_in(idx);
      end
      if (stop_outs > 0 && (out_q.size() - obase) >= stop_outs) done = 1'b1;
      else if (stop_outs == 0 && idx >= stim_q.size() && seen_busy && !busy) done = 1'b1;
    end
    check("run_completed", 32'(done), 32'd1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int ob, eb, cb, ub, vb;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef FILTER_STREAM_ALIGNER_CHECK_EN
    in_last   = 1'b0;
`endif
    tick(3);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_sr_enable", 32'(sr_enable), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_sr_clear",  32'(sr_clear),  32'd1);
`ifdef FILTER_STREAM_ALIGNER_CHECK_EN
    check("rst_err_len",   32'(err_len),   32'd0);
`endif
    reset_n = 1'b1;
    tick(2);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_sr_clear", 32'(sr_clear), 32'd0);

    // Two lines back to back; line 2 is already offered while line 1 flushes.
    ob = out_q.size(); eb = en_count; cb = clr_count; ub = up_count; vb = en_val_q.size();
    stim_q.delete();
    for (int i = 1; i <= 8; i++) stim_q.push_back(DW'(i));
    for (int i = 101; i <= 108; i++) stim_q.push_back(DW'(i));
    run(1'b0, 0);
    check("b2b_out_count", 32'(out_q.size() - ob), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("b2b_data_%0d", i), 32'(out_q[ob+i]), (i < 8) ? 32'(i + 1) : 32'(101 + i - 8));
      check($sformatf("b2b_last_%0d", i), 32'(last_q[ob+i]), 32'((i == 7) || (i == 15)));
    end
    check("b2b_enables",   32'(en_count - eb),  32'd24);
    check("b2b_clears",    32'(clr_count - cb), 32'd2);
    check("b2b_upstream",  32'(up_count - ub),  32'd16);
    check("b2b_busy_end",  32'(busy),           32'd0);
    for (int i = 0; i < 24; i++) begin
      if ((i % 12) >= 8)
        check($sformatf("flush_val_%0d", i), 32'(en_val_q[vb+i]), 32'd0);
      else
        check($sformatf("wr_val_%0d", i), 32'(en_val_q[vb+i]),
              (i < 12) ? 32'(i + 1) : 32'(101 + i - 12));
    end

    // Backpressure: out_ready 1,0,0,1 repeating.
    ob = out_q.size(); eb = en_count; vb = bp_viol;
    stim_q.delete();
    for (int i = 21; i <= 28; i++) stim_q.push_back(DW'(i));
    run(1'b1, 0);
    check("bp_out_count", 32'(out_q.size() - ob), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bp_data_%0d", i), 32'(out_q[ob+i]), 32'(21 + i));
      check($sformatf("bp_last_%0d", i), 32'(last_q[ob+i]), 32'(i == 7));
    end
    check("bp_enables",    32'(en_count - eb), 32'd12);
    check("bp_violations", 32'(bp_viol - vb),  32'd0);

    // Reset in the middle of STREAM after three outputs.
    ob = out_q.size();
    stim_q.delete();
    for (int i = 31; i <= 38; i++) stim_q.push_back(DW'(i));
    run(1'b0, 3);
    check("mid_outs_before", 32'(out_q.size() - ob), 32'd3);
    check("mid_valid_before", 32'(out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_async_valid", 32'(out_valid), 32'd0);
    check("mid_async_clear", 32'(sr_clear),  32'd1);
    check("mid_async_busy",  32'(busy),      32'd0);
    check("mid_async_ready", 32'(in_ready),  32'd0);
    check("mid_async_data",  32'(out_data),  32'd0);
    in_valid = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    ob = out_q.size(); eb = en_count;
    stim_q.delete();
    for (int i = 41; i <= 48; i++) stim_q.push_back(DW'(i));
    run(1'b0, 0);
    check("post_rst_count", 32'(out_q.size() - ob), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("post_rst_data_%0d", i), 32'(out_q[ob+i]), 32'(41 + i));
    check("post_rst_enables", 32'(en_count - eb), 32'd12);

`ifdef FILTER_STREAM_ALIGNER_CHECK_EN
    check("chk_err_clean", 32'(err_len), 32'd0);
    last_pos = 5;
    stim_q.delete();
    for (int i = 51; i <= 58; i++) stim_q.push_back(DW'(i));
    run(1'b0, 0);
    check("chk_err_set", 32'(err_len), 32'd1);
    last_pos = L - 1;
    stim_q.delete();
    for (int i = 61; i <= 68; i++) stim_q.push_back(DW'(i));
    run(1'b0, 0);
    check("chk_err_sticky", 32'(err_len), 32'd1);
    reset_n = 1'b0;
    #1;
    check("chk_err_reset", 32'(err_len), 32'd0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", compares);
    $fatal(1, "watchdog expired");
  end

endmodule
